// File: rtl/pipe_hazard_ctrl.sv
// Load-enable and bubble control for the five-stage LC-3b pipeline registers.
// Resolves load-use, I/D-memory wait and MEM-stage redirect hazards, and keeps stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int FLUSH_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               imem_read,
  input  logic               imem_resp,
  input  logic               dmem_req,
  input  logic               dmem_resp,
  input  logic               idex_ldr_read,
  input  logic [2:0]         idex_dest,
  input  logic [2:0]         ifid_src1,
  input  logic [2:0]         ifid_src2,
  input  logic               ifid_src1_used,
  input  logic               ifid_src2_used,
  input  logic               br_taken,
  input  logic [15:0]        br_target,
  output logic               load_pc,
  output logic               pc_redirect,
  output logic [15:0]        pc_target,
  output logic               load_ifid,
  output logic               load_idex,
  output logic               load_exmem,
  output logic               load_memwb,
  output logic               ifid_bubble,
  output logic               idex_bubble,
  output logic               exmem_bubble,
  output logic               memwb_bubble,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [FLUSH_W-1:0] flush_count
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t             state, state_nxt;
  logic [15:0]        tgt_q, tgt_nxt;
  logic [CNT_W-1:0]   stall_q;
  logic [FLUSH_W-1:0] flush_q;
  logic               dfrz, ifrz, lu, flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign dfrz = dmem_req & ~dmem_resp;
  assign ifrz = imem_read & ~imem_resp;
  assign lu   = idex_ldr_read &
                ((ifid_src1_used & (ifid_src1 == idex_dest)) |
                 (ifid_src2_used & (ifid_src2 == idex_dest)));

  always_comb begin
    load_pc      = 1'b1;
    load_ifid    = 1'b1;
    load_idex    = 1'b1;
    load_exmem   = 1'b1;
    load_memwb   = 1'b1;
    ifid_bubble  = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = tgt_q;
    tgt_nxt      = tgt_q;
    state_nxt    = state;
    flush_inc    = 1'b0;

    case (state)
      RUN: begin
        if (dfrz) begin
          load_pc      = 1'b0;
          load_ifid    = 1'b0;
          load_idex    = 1'b0;
          load_exmem   = 1'b0;
          memwb_bubble = 1'b1;
        end else if (br_taken && !ifrz) begin
          // Target bypasses the holding register so the PC redirects this cycle.
          pc_redirect  = 1'b1;
          pc_target    = br_target;
          ifid_bubble  = 1'b1;
          idex_bubble  = 1'b1;
          exmem_bubble = 1'b1;
          flush_inc    = 1'b1;
        end else if (br_taken) begin
          // Fetch in flight: hold the target until the I-mem answers.
          load_pc      = 1'b0;
          pc_target    = br_target;
          tgt_nxt      = br_target;
          ifid_bubble  = 1'b1;
          idex_bubble  = 1'b1;
          exmem_bubble = 1'b1;
          flush_inc    = 1'b1;
          state_nxt    = SQUASH;
        end else if (lu || ifrz) begin
          load_pc     = 1'b0;
          load_ifid   = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      SQUASH: begin
        pc_redirect = 1'b1;
        ifid_bubble = 1'b1;
        if (imem_resp) state_nxt = RUN;
        else           load_pc   = 1'b0;
        if (dfrz) begin
          load_idex    = 1'b0;
          load_exmem   = 1'b0;
          memwb_bubble = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (!reset_n) begin
      load_pc      = 1'b0;
      load_ifid    = 1'b0;
      load_idex    = 1'b0;
      load_exmem   = 1'b0;
      load_memwb   = 1'b0;
      ifid_bubble  = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      memwb_bubble = 1'b0;
      pc_redirect  = 1'b0;
      pc_target    = 16'h0000;
      flush_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      tgt_q   <= 16'h0000;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state <= state_nxt;
      tgt_q <= tgt_nxt;
      if (!load_pc)  stall_q <= sat_inc(stall_q);
      if (flush_inc) flush_q <= flush_q + FLUSH_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change 1ns after the rising edge,
// outputs are compared on the falling edge against hand-computed values.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_read, imem_resp, dmem_req, dmem_resp;
  logic        idex_ldr_read;
  logic [2:0]  idex_dest, ifid_src1, ifid_src2;
  logic        ifid_src1_used, ifid_src2_used;
  logic        br_taken;
  logic [15:0] br_target;
  logic        load_pc, pc_redirect, load_ifid, load_idex, load_exmem, load_memwb;
  logic        ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble;
  logic [15:0] pc_target;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.CNT_W(16), .FLUSH_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .idex_ldr_read(idex_ldr_read), .idex_dest(idex_dest),
    .ifid_src1(ifid_src1), .ifid_src2(ifid_src2),
    .ifid_src1_used(ifid_src1_used), .ifid_src2_used(ifid_src2_used),
    .br_taken(br_taken), .br_target(br_target),
    .load_pc(load_pc), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .load_ifid(load_ifid), .load_idex(load_idex), .load_exmem(load_exmem),
    .load_memwb(load_memwb), .ifid_bubble(ifid_bubble), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .memwb_bubble(memwb_bubble),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // A D-mem freeze and a redirect must never be presented together.
  always @(posedge clk)
    if (reset_n) assert (!(dmem_req && !dmem_resp && br_taken))
      else $error("dmem freeze coincides with br_taken");

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_read = 1'b0; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b1;
    idex_ldr_read = 1'b0; idex_dest = 3'd0; ifid_src1 = 3'd1; ifid_src2 = 3'd2;
    ifid_src1_used = 1'b0; ifid_src2_used = 1'b0;
    br_taken = 1'b0; br_target = 16'h0000;
  endtask

  // Load-use pattern: ID/EX loads r3, IF/ID reads r3 via src1.
  task automatic set_lu();
    idex_ldr_read = 1'b1; idex_dest = 3'd3; ifid_src1 = 3'd3; ifid_src1_used = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    #2;
    chk("rst_load_pc",  32'(load_pc), 0);
    chk("rst_load_memwb", 32'(load_memwb), 0);
    chk("rst_pc_target", 32'(pc_target), 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    chk("rst_flush", 32'(flush_count), 0);
    step(); step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_loads", 32'({load_pc, load_ifid, load_idex, load_exmem, load_memwb}), 32'h1F);
    chk("idle_bubbles", 32'({ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble, pc_redirect}), 0);

    // T1 load-use on src1
    step(); set_lu();
    @(negedge clk);
    chk("t1_load_pc", 32'(load_pc), 0);
    chk("t1_load_ifid", 32'(load_ifid), 0);
    chk("t1_idex_bubble", 32'(idex_bubble), 1);
    chk("t1_adv", 32'({load_idex, load_exmem, load_memwb}), 32'h7);
    step(); idle();
    @(negedge clk);
    chk("t1_after_loads", 32'({load_pc, load_ifid, load_idex, load_exmem, load_memwb}), 32'h1F);
    chk("t1_after_bubble", 32'(idex_bubble), 0);
    chk("t1_stall", 32'(stall_cycles), 1);

    // T2 src1 unused, src2=5 differs: no stall; then src2=3 used: stall
    step(); set_lu(); ifid_src1_used = 1'b0; ifid_src2 = 3'd5; ifid_src2_used = 1'b1;
    @(negedge clk);
    chk("t2_no_stall", 32'({load_pc, idex_bubble}), 32'h2);
    step(); ifid_src2 = 3'd3;
    @(negedge clk);
    chk("t2_src2_stall", 32'({load_pc, idex_bubble}), 32'h1);
    step(); idle();
    @(negedge clk);
    chk("t2_stall", 32'(stall_cycles), 2);

    // T3 redirect with fetch ready
    step(); imem_read = 1'b1; br_taken = 1'b1; br_target = 16'h1234;
    @(negedge clk);
    chk("t3_redirect", 32'({load_pc, pc_redirect}), 32'h3);
    chk("t3_target", 32'(pc_target), 32'h1234);
    chk("t3_bubbles", 32'({ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble}), 32'hE);
    chk("t3_flush_pre", 32'(flush_count), 0);
    step(); br_taken = 1'b0; br_target = 16'h0000;
    @(negedge clk);
    chk("t3_flush_post", 32'(flush_count), 1);
    chk("t3_no_redirect", 32'(pc_redirect), 0);

    // T4 redirect while fetch stalled -> SQUASH
    step(); imem_resp = 1'b0; br_taken = 1'b1; br_target = 16'h2000;
    @(negedge clk);
    chk("t4_enter_load_pc", 32'(load_pc), 0);
    chk("t4_enter_ifid", 32'({load_ifid, ifid_bubble}), 32'h3);
    chk("t4_enter_bubbles", 32'({idex_bubble, exmem_bubble}), 32'h3);
    step(); br_taken = 1'b0; br_target = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_sq_load_pc", 32'(load_pc), 0);
      chk("t4_sq_redirect", 32'({pc_redirect, ifid_bubble}), 32'h3);
      chk("t4_sq_target", 32'(pc_target), 32'h2000);
      step();
    end
    imem_resp = 1'b1;
    @(negedge clk);
    chk("t4_exit_loads", 32'({load_pc, load_ifid, ifid_bubble, pc_redirect}), 32'hF);
    chk("t4_exit_target", 32'(pc_target), 32'h2000);
    chk("t4_flush", 32'(flush_count), 2);
    step(); idle();
    @(negedge clk);
    chk("t4_back_run", 32'({pc_redirect, ifid_bubble, load_pc}), 32'h1);
    chk("t4_stall", 32'(stall_cycles), 6);

    // T5 D-mem freeze for 3 cycles over a load-use, then 1 load-use bubble
    step(); set_lu(); dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_frz_loads", 32'({load_pc, load_ifid, load_idex, load_exmem, load_memwb}), 32'h01);
      chk("t5_frz_bubbles", 32'({ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble}), 32'h1);
      step();
    end
    dmem_resp = 1'b1;
    @(negedge clk);
    chk("t5_lu_loads", 32'({load_pc, load_ifid, load_idex, load_exmem, load_memwb}), 32'h07);
    chk("t5_lu_bubbles", 32'({idex_bubble, memwb_bubble}), 32'h2);
    step(); idle();
    @(negedge clk);
    chk("t5_stall", 32'(stall_cycles), 10);
    chk("t5_resume", 32'(load_pc), 1);

    // SQUASH with a D-mem freeze: back end frozen, PC/IF/ID still exit
    step(); imem_read = 1'b1; imem_resp = 1'b0; br_taken = 1'b1; br_target = 16'h3000;
    step(); br_taken = 1'b0; imem_resp = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b0;
    @(negedge clk);
    chk("sqd_front", 32'({load_pc, load_ifid, ifid_bubble, pc_redirect}), 32'hF);
    chk("sqd_back", 32'({load_idex, load_exmem, load_memwb, memwb_bubble}), 32'h3);
    step(); idle();

    // T6 async reset during SQUASH
    imem_read = 1'b1; imem_resp = 1'b0; br_taken = 1'b1; br_target = 16'h4444;
    step(); br_taken = 1'b0;
    @(negedge clk);
    chk("t6_in_squash", 32'(pc_redirect), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_outs", 32'({load_pc, load_ifid, load_memwb, pc_redirect, ifid_bubble}), 0);
    chk("t6_rst_target", 32'(pc_target), 0);
    chk("t6_rst_counters", 32'({stall_cycles, flush_count}), 0);
    step(); idle(); reset_n = 1'b1;
    @(negedge clk);
    chk("t6_run_after", 32'({pc_redirect, ifid_bubble, load_pc}), 32'h1);
    chk("t6_target_clear", 32'(pc_target), 0);

    // flush_count wraps after 256 accepted redirects
    step(); br_taken = 1'b1; br_target = 16'h0100;
    repeat (255) step();
    chk("flush_255", 32'(flush_count), 32'hFF);
    step();
    chk("flush_wrap", 32'(flush_count), 0);
    br_taken = 1'b0;

    // stall_cycles saturates at 0xFFFF
    set_lu();
    repeat (65534) step();
    chk("stall_fffe", 32'(stall_cycles), 32'hFFFE);
    repeat (3) step();
    chk("stall_sat", 32'(stall_cycles), 32'hFFFF);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
